// File: rtl/key_loader.sv
// key_loader: serial parity-checked key intake driving a stable parallel key bus.
module key_loader #(
  parameter int KEY_W = 3,
  parameter logic [KEY_W-1:0] DECOY = '0,
  parameter int MAX_FAIL = 3,
  parameter int TIMEOUT = 16,
  localparam int FW = $clog2(MAX_FAIL + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_start,
  input  logic             key_bit,
  input  logic             key_bit_valid,
  output logic             key_bit_ready,
  output logic [KEY_W-1:0] key_out,
  output logic             key_active,
  output logic             busy,
  output logic             err,
  output logic             locked_out,
  output logic [FW-1:0]    fail_count
);
  localparam int CW = $clog2(KEY_W + 1);
  localparam int IW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, SHIFT, CHECK, ACTIVE, LOCKOUT} state_t;
  state_t state_q, state_d;
  logic [KEY_W-1:0] key_q, key_d, shadow_q, shadow_d;
  logic active_q, active_d, err_q, err_d, lock_q, lock_d, par_q, par_d;
  logic [FW-1:0] fail_q, fail_d, fail_inc;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idle_q, idle_d;
  logic accept, pass, fail_now;
  assign key_bit_ready = state_q == SHIFT;
  assign busy = state_q == SHIFT || state_q == CHECK;
  assign accept = key_bit_valid & key_bit_ready;
  assign pass = ~(^shadow_q ^ par_q);
  assign fail_inc = (fail_q == FW'(MAX_FAIL)) ? fail_q : fail_q + 1'b1;
  assign key_out = key_q;
  assign key_active = active_q;
  assign err = err_q;
  assign locked_out = lock_q;
  assign fail_count = fail_q;
  always_comb begin
    state_d = state_q;
    key_d = key_q;
    active_d = active_q;
    err_d = 1'b0;
    lock_d = lock_q;
    fail_d = fail_q;
    shadow_d = shadow_q;
    par_d = par_q;
    cnt_d = cnt_q;
    idle_d = idle_q;
    fail_now = 1'b0;
    if (load_start && (state_q == IDLE || state_q == ACTIVE || state_q == SHIFT)) begin
      state_d = SHIFT;
      key_d = DECOY;
      active_d = 1'b0;
      shadow_d = '0;
      par_d = 1'b0;
      cnt_d = '0;
      idle_d = '0;
    end else if (state_q == SHIFT) begin
      if (accept) begin
        idle_d = '0;
        // the bit after KEY_W data bits is parity; it ends the frame
        if (cnt_q == CW'(KEY_W)) begin
          par_d = key_bit;
          state_d = CHECK;
        end else begin
          shadow_d = shadow_q | (KEY_W'(key_bit) << cnt_q);
          cnt_d = cnt_q + 1'b1;
        end
      end else begin
        idle_d = idle_q + 1'b1;
        fail_now = idle_q == IW'(TIMEOUT - 1);
      end
    end else if (state_q == CHECK) begin
      if (pass) begin
        key_d = shadow_q;
        active_d = 1'b1;
        fail_d = '0;
        state_d = ACTIVE;
      end else fail_now = 1'b1;
    end
    if (fail_now) begin
      err_d = 1'b1;
      fail_d = fail_inc;
      lock_d = fail_inc == FW'(MAX_FAIL);
      state_d = lock_d ? LOCKOUT : IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      key_q <= DECOY;
      active_q <= 1'b0;
      err_q <= 1'b0;
      lock_q <= 1'b0;
      fail_q <= '0;
      shadow_q <= '0;
      par_q <= 1'b0;
      cnt_q <= '0;
      idle_q <= '0;
    end else begin
      state_q <= state_d;
      key_q <= key_d;
      active_q <= active_d;
      err_q <= err_d;
      lock_q <= lock_d;
      fail_q <= fail_d;
      shadow_q <= shadow_d;
      par_q <= par_d;
      cnt_q <= cnt_d;
      idle_q <= idle_d;
    end
  end
endmodule
